// File: rtl/long_mul_seq.sv
// Iterative shift-add multiplier producing a 2*WIDTH product, one multiplier bit per cycle.
// Signed operands are multiplied as magnitudes and the product is negated at the end.
module long_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_n,
   output logic             flag_z
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   mcand, mplier;
   logic [2*WIDTH-1:0] acc;
   logic               sign;
   logic               accept, last;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;

   // Handshake: a request is taken on any rising edge where start=1 and ready=1;
   // start while busy is ignored. done pulses for one cycle when results are valid.
   assign ready  = (state == IDLE) || (state == DONE);
   assign busy   = (state == CALC) || (state == FIX);
   assign done   = (state == DONE);
   assign accept = ready && start;
   assign last   = (count == CW'(WIDTH - 1));

   // Most-negative input negates to itself, which reads correctly as unsigned 2^(W-1).
   assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
   assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
   assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
   assign prod  = sign ? -acc : acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (last) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = start ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         sign      <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
         flag_z    <= 1'b1;
      end else if (accept) begin
         mcand  <= mag_a;
         mplier <= mag_b;
         sign   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
         acc    <= '0;
         count  <= '0;
      end else if (state == CALC) begin
         // Carry out of the add becomes the new top bit after the right shift.
         acc    <= {sum, acc[WIDTH-1:1]};
         mplier <= mplier >> 1;
         count  <= count + CW'(1);
      end else if (state == FIX) begin
         result_lo <= prod[WIDTH-1:0];
         result_hi <= prod[2*WIDTH-1:WIDTH];
         flag_z    <= (prod == '0);
      end
   end

   assign flag_n = result_hi[WIDTH-1];

endmodule

// File: tb/tb_long_mul_seq.sv
// Directed bench for long_mul_seq: products, flags, latency, ignored starts,
// back-to-back requests and mid-operation reset.
module tb_long_mul_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] a, b;
   logic        ready, busy, done;
   logic [31:0] result_lo, result_hi;
   logic        flag_n, flag_z;

   int n_cmp = 0;
   int n_err = 0;

   long_mul_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .a(a), .b(b), .ready(ready), .busy(busy), .done(done),
      .result_lo(result_lo), .result_hi(result_hi),
      .flag_n(flag_n), .flag_z(flag_z)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present an operation, let the edge sample it, then count edges until done.
   // poke_at > 0 drives a fresh start with other operands during that cycle of CALC.
   task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic s,
                        input int poke_at, output int lat);
      start = 1'b1; a = oa; b = ob; is_signed = s;
      tick();
      start = 1'b0;
      a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
      check("busy_after_accept", {63'd0, busy}, 64'd1);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == poke_at) begin
            start = 1'b1; a = 32'd9; b = 32'd9; is_signed = 1'b0;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [63:0] exp_p,
                               input logic exp_n, input logic exp_z);
      check({tag, "_product"}, {result_hi, result_lo}, exp_p);
      check({tag, "_n"}, {63'd0, flag_n}, {63'd0, exp_n});
      check({tag, "_z"}, {63'd0, flag_z}, {63'd0, exp_z});
   endtask

   initial begin
      int lat;
      int pulses;

      reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
      tick();
      check("rst_ready", {63'd0, ready}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check_result("rst", 64'd0, 1'b0, 1'b1);
      reset = 1'b0;
      tick();

      // Unsigned 3*5
      do_op(32'd3, 32'd5, 1'b0, 0, lat);
      check("u3x5_latency", 64'(lat), 64'd33);
      check_result("u3x5", 64'h0000_0000_0000_000F, 1'b0, 1'b0);
      tick();
      check("u3x5_done_drop", {63'd0, done}, 64'd0);

      // Unsigned all-ones squared
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, lat);
      check("umax_latency", 64'(lat), 64'd33);
      check_result("umax", 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);
      tick();

      // Signed -1 * 7
      do_op(32'hFFFF_FFFF, 32'd7, 1'b1, 0, lat);
      check("sm1x7_latency", 64'(lat), 64'd33);
      check_result("sm1x7", 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0);
      tick();

      // Signed most-negative squared
      do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, lat);
      check("smin2_latency", 64'(lat), 64'd33);
      check_result("smin2", 64'h4000_0000_0000_0000, 1'b0, 1'b0);
      tick();

      // Signed 0 * -5 with an ignored start during CALC
      do_op(32'd0, 32'hFFFF_FFFB, 1'b1, 5, lat);
      check("s0xm5_latency", 64'(lat), 64'd33);
      check_result("s0xm5", 64'd0, 1'b0, 1'b1);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) pulses++;
      end
      check("s0xm5_no_extra_done", 64'(pulses), 64'd0);
      check("s0xm5_idle_ready", {63'd0, ready}, 64'd1);

      // Back-to-back: 7*8, then 2*3 requested while in DONE
      do_op(32'd7, 32'd8, 1'b0, 0, lat);
      check("b2b_first_latency", 64'(lat), 64'd33);
      check_result("b2b_first", 64'd56, 1'b0, 1'b0);
      start = 1'b1; a = 32'd2; b = 32'd3; is_signed = 1'b0;
      tick();
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      check("b2b_done_drop", {63'd0, done}, 64'd0);
      check("b2b_busy", {63'd0, busy}, 64'd1);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 32) check("b2b_held_in_fix", {result_hi, result_lo}, 64'd56);
         if (done) begin
            lat = i;
            break;
         end
      end
      check("b2b_second_latency", 64'(lat), 64'd33);
      check_result("b2b_second", 64'd6, 1'b0, 1'b0);
      tick();

      // Reset at CALC count=10
      start = 1'b1; a = 32'd3; b = 32'd5; is_signed = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("pre_rst_busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      #1;
      check("midrst_ready", {63'd0, ready}, 64'd1);
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_done", {63'd0, done}, 64'd0);
      check_result("midrst", 64'd0, 1'b0, 1'b1);
      tick();
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) pulses++;
      end
      check("midrst_no_done", 64'(pulses), 64'd0);

      // Fresh operation after reset, signed 6 * -7
      do_op(32'd6, 32'hFFFF_FFF9, 1'b1, 0, lat);
      check("post_rst_latency", 64'(lat), 64'd33);
      check_result("post_rst", 64'hFFFF_FFFF_FFFF_FFD6, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
